// File: rtl/design_mux_switcher.sv
// Guarded pad multiplexer: isolates the pads, holds all designs in reset, then releases only the selected design.
// Optional feature macro: TEST_PATTERN_EN (ID 2**SEL_W-1 drives a fixed pattern instead of a design).
module design_mux_switcher #(
    parameter int NUM_DESIGNS  = 4,
    parameter int IO_W         = 38,
    parameter int SEL_W        = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int RST_CYCLES   = 8,
    parameter int DEFAULT_ID   = 0
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n,
    input  logic                        sel_strobe,
    input  logic [SEL_W-1:0]            sel_id,
    input  logic [3:0]                  debug,
    input  logic [NUM_DESIGNS*IO_W-1:0] dsg_io_out,
    input  logic [NUM_DESIGNS*IO_W-1:0] dsg_io_oeb,
    output logic [NUM_DESIGNS-1:0]      dsg_rst_n,
    output logic [IO_W-1:0]             io_out,
    output logic [IO_W-1:0]             io_oeb,
    output logic [SEL_W-1:0]            active_id,
    output logic                        active_valid,
    output logic                        busy
);

    localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);
`ifdef TEST_PATTERN_EN
    localparam logic [SEL_W-1:0] TP_ID = '1;
`endif

    typedef enum logic [1:0] {
        S_OFF,
        S_ISOLATE,
        S_RESET_NEW,
        S_ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DESIGNS-1:0] rst_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               req;

`ifndef TEST_PATTERN_EN
    logic unused_debug;
    assign unused_debug = ^debug;
`endif

    function automatic logic routable(input logic [SEL_W-1:0] t);
        logic r;
        r = (32'(t) < NUM_DESIGNS);
`ifdef TEST_PATTERN_EN
        r = r | (t == TP_ID);
`endif
        return r;
    endfunction

    // Strobe synchroniser; a request is a single-cycle rise of the synchronised strobe
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sel_strobe;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign req = sync2_q & ~sync3_q;

    // Reset lands in ISOLATE so the default design is brought up without any request
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_ISOLATE;
            target_q  <= SEL_W'(DEFAULT_ID);
            cnt_q     <= GUARD_LD;
            dsg_rst_n <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            dsg_rst_n <= rst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_OFF: begin
                if (req) begin
                    state_d  = S_ISOLATE;
                    target_d = sel_id;
                    cnt_d    = GUARD_LD;
                end
            end
            S_ISOLATE: begin
                if (req) begin
                    target_d = sel_id;
                    cnt_d    = GUARD_LD;
                end else if (cnt_q == '0) begin
                    if (routable(target_q)) begin
                        state_d = S_RESET_NEW;
                        cnt_d   = RST_LD;
                    end else begin
                        state_d = S_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESET_NEW: begin
                if (req) begin
                    state_d  = S_ISOLATE;
                    target_d = sel_id;
                    cnt_d    = GUARD_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (req && (sel_id != target_q)) begin
                    state_d  = S_ISOLATE;
                    target_d = sel_id;
                    cnt_d    = GUARD_LD;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Release is computed from the next state so it coincides with the ACTIVE entry edge
    always_comb begin
        rst_d = '0;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            rst_d[d] = (state_d == S_ACTIVE) && (target_d == SEL_W'(d));
        end
    end

    always_comb begin
        io_out = '1;
        io_oeb = '1;
        if (state_q == S_ACTIVE) begin
            for (int d = 0; d < NUM_DESIGNS; d++) begin
                if (target_q == SEL_W'(d)) begin
                    io_out = dsg_io_out[d*IO_W +: IO_W];
                    io_oeb = dsg_io_oeb[d*IO_W +: IO_W];
                end
            end
`ifdef TEST_PATTERN_EN
            if (target_q == TP_ID) begin
                io_out[31:20] = 12'hAA5;
                io_out[19:16] = debug;
                io_oeb[31:16] = '0;
            end
`endif
        end
    end

    assign active_id    = target_q;
    assign active_valid = (state_q == S_ACTIVE);
    assign busy         = wb_rst_n & ((state_q == S_ISOLATE) | (state_q == S_RESET_NEW));

endmodule

// File: tb/tb_design_mux_switcher.sv
// Self-checking bench for design_mux_switcher: directed scenarios plus randomized strobes against a timeline model.
module tb_design_mux_switcher;

    localparam int NUM = 4;
    localparam int IO_W = 38;
    localparam int SEL_W = 4;
    localparam int G = 16;
    localparam int R = 8;
    localparam int DEF = 0;

    logic                  wb_clk_i = 1'b0;
    logic                  wb_rst_n;
    logic                  sel_strobe;
    logic [SEL_W-1:0]      sel_id;
    logic [3:0]            debug;
    logic [NUM*IO_W-1:0]   dsg_io_out;
    logic [NUM*IO_W-1:0]   dsg_io_oeb;
    logic [NUM-1:0]        dsg_rst_n;
    logic [IO_W-1:0]       io_out;
    logic [IO_W-1:0]       io_oeb;
    logic [SEL_W-1:0]      active_id;
    logic                  active_valid;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    design_mux_switcher #(
        .NUM_DESIGNS(NUM), .IO_W(IO_W), .SEL_W(SEL_W),
        .GUARD_CYCLES(G), .RST_CYCLES(R), .DEFAULT_ID(DEF)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .sel_strobe(sel_strobe), .sel_id(sel_id),
        .debug(debug), .dsg_io_out(dsg_io_out), .dsg_io_oeb(dsg_io_oeb), .dsg_rst_n(dsg_rst_n),
        .io_out(io_out), .io_oeb(io_oeb), .active_id(active_id), .active_valid(active_valid),
        .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Timeline model: a switch completes G+R edges after it starts; routability is judged after G edges.
    int             m_mode;   // 0 = off, 1 = switching, 2 = active
    logic [3:0]     m_target;
    int             m_rem;
    logic           s1, s2, s3;
    logic           m_req;

    function automatic logic tb_routable(input logic [3:0] t);
`ifdef TEST_PATTERN_EN
        return (t < NUM) || (t == 4'hF);
`else
        return (t < NUM);
`endif
    endfunction

    assign m_req = s2 && !s3 && !(m_mode == 2 && sel_id == m_target);

    always @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            m_mode <= 1; m_target <= 4'(DEF); m_rem <= G + R;
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
        end else begin
            if (m_req) begin
                m_mode <= 1; m_target <= sel_id; m_rem <= G + R;
            end else if (m_mode == 1) begin
                m_rem <= m_rem - 1;
                if (m_rem - 1 == R && !tb_routable(m_target)) m_mode <= 0;
                else if (m_rem - 1 == 0) m_mode <= 2;
            end
            s1 <= sel_strobe; s2 <= s1; s3 <= s2;
        end
    end

    logic [NUM-1:0]  exp_rst;
    logic [IO_W-1:0] exp_out, exp_oeb;
    logic            exp_busy, exp_valid;

    always_comb begin
        exp_valid = (m_mode == 2);
        exp_busy  = wb_rst_n && (m_mode == 1);
        exp_rst   = '0;
        exp_out   = '1;
        exp_oeb   = '1;
        if (m_mode == 2 && m_target < NUM) begin
            exp_rst = NUM'(1) << m_target;
            exp_out = dsg_io_out[m_target*IO_W +: IO_W];
            exp_oeb = dsg_io_oeb[m_target*IO_W +: IO_W];
        end
`ifdef TEST_PATTERN_EN
        if (m_mode == 2 && m_target == 4'hF) begin
            exp_out[31:16] = {12'hAA5, debug};
            exp_oeb[31:16] = '0;
        end
`endif
    end

    function automatic logic [IO_W-1:0] slice(input logic [NUM*IO_W-1:0] v, input int d);
        return v[d*IO_W +: IO_W];
    endfunction

    task automatic step();
        logic [63:0] r;
        @(negedge wb_clk_i);
        for (int d = 0; d < NUM; d++) begin
            r = {$urandom, $urandom};
            dsg_io_out[d*IO_W +: IO_W] = r[IO_W-1:0];
            r = {$urandom, $urandom};
            dsg_io_oeb[d*IO_W +: IO_W] = r[IO_W-1:0];
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe_low();
        sel_strobe = 1'b0;
        steps(3);
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0; sel_strobe = 1'b0; sel_id = '0; debug = '0;
        dsg_io_out = '0; dsg_io_oeb = '0;
        steps(3);
        n_vec++; if (dsg_rst_n !== 4'b0000) begin n_err++; $display("FAIL reset_dsg_rst_n got %b want 0000", dsg_rst_n); end
        n_vec++; if (io_out !== '1) begin n_err++; $display("FAIL reset_io_out got %h want all ones", io_out); end
        n_vec++; if (io_oeb !== '1) begin n_err++; $display("FAIL reset_io_oeb got %h want all ones", io_oeb); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (active_valid !== 1'b0) begin n_err++; $display("FAIL reset_active_valid got %b want 0", active_valid); end
    endtask

    task automatic test_bringup();
        wb_rst_n = 1'b1;
        step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bringup_busy got %b want 1", busy); end
        steps(22);
        n_vec++; if (active_valid !== 1'b0) begin n_err++; $display("FAIL bringup_early got valid=%b want 0 at edge 23", active_valid); end
        step();
        n_vec++; if (active_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bringup_valid got valid=%b busy=%b want 1/0", active_valid, busy); end
        n_vec++; if (dsg_rst_n !== 4'b0001) begin n_err++; $display("FAIL bringup_rst got %b want 0001", dsg_rst_n); end
        n_vec++; if (io_out !== slice(dsg_io_out, 0) || io_oeb !== slice(dsg_io_oeb, 0)) begin
            n_err++; $display("FAIL bringup_route got %h/%h want %h/%h", io_out, io_oeb, slice(dsg_io_out, 0), slice(dsg_io_oeb, 0)); end
    endtask

    task automatic test_switch();
        int seen;
        seen = -1;
        sel_id = 4'd2; sel_strobe = 1'b1;
        steps(4);
        n_vec++; if (io_oeb !== '1 || dsg_rst_n !== 4'b0000) begin n_err++; $display("FAIL switch_isolate got oeb=%h rst=%b want all ones/0000", io_oeb, dsg_rst_n); end
        for (int k = 5; k <= 40; k++) begin
            step();
            if (seen < 0 && dsg_rst_n === 4'b0100) seen = k;
        end
        n_vec++; if (seen != 27) begin n_err++; $display("FAIL switch_latency got edge %0d want edge 27 after strobe", seen); end
        n_vec++; if (io_oeb !== slice(dsg_io_oeb, 2) || active_id !== 4'd2) begin
            n_err++; $display("FAIL switch_route got oeb=%h id=%0d want %h/2", io_oeb, active_id, slice(dsg_io_oeb, 2)); end
        strobe_low();
    endtask

    task automatic test_same_id();
        int bad;
        bad = 0;
        sel_id = 4'd2; sel_strobe = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (busy !== 1'b0 || dsg_rst_n !== 4'b0100 || io_out !== slice(dsg_io_out, 2)) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL same_id_glitch got %0d disturbed cycles want 0", bad); end
        strobe_low();
    endtask

    task automatic test_retarget();
        int seen, rel1;
        seen = -1; rel1 = 0;
        sel_id = 4'd1; sel_strobe = 1'b1;
        steps(4);
        sel_strobe = 1'b0;
        steps(2);
        sel_id = 4'd3; sel_strobe = 1'b1;
        for (int k = 7; k <= 45; k++) begin
            step();
            if (dsg_rst_n[1] === 1'b1) rel1++;
            if (seen < 0 && active_valid === 1'b1) seen = k;
        end
        n_vec++; if (rel1 != 0) begin n_err++; $display("FAIL retarget_old_release got %0d cycles with rst_n[1]=1 want 0", rel1); end
        n_vec++; if (seen != 33) begin n_err++; $display("FAIL retarget_latency got edge %0d want edge 33", seen); end
        n_vec++; if (active_id !== 4'd3 || dsg_rst_n !== 4'b1000) begin n_err++; $display("FAIL retarget_end got id=%0d rst=%b want 3/1000", active_id, dsg_rst_n); end
        strobe_low();
    endtask

    task automatic test_unroutable();
        sel_id = 4'd7; sel_strobe = 1'b1;
        steps(18);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL unroutable_busy got %b want 1 at edge 18", busy); end
        step();
        n_vec++; if (busy !== 1'b0 || active_valid !== 1'b0 || dsg_rst_n !== 4'b0000) begin
            n_err++; $display("FAIL unroutable_off got busy=%b valid=%b rst=%b want 0/0/0000", busy, active_valid, dsg_rst_n); end
        n_vec++; if (io_out !== '1 || io_oeb !== '1) begin n_err++; $display("FAIL unroutable_pads got %h/%h want all ones", io_out, io_oeb); end
        strobe_low();
    endtask

    task automatic test_reset_mid();
        sel_id = 4'd1; sel_strobe = 1'b1;
        steps(22);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_pre got busy=%b want 1", busy); end
        #2 wb_rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || active_valid !== 1'b0 || dsg_rst_n !== 4'b0000 || io_out !== '1 || io_oeb !== '1) begin
            n_err++; $display("FAIL midreset_async got busy=%b valid=%b rst=%b out=%h want reset values", busy, active_valid, dsg_rst_n, io_out); end
        n_vec++; if (active_id !== 4'(DEF)) begin n_err++; $display("FAIL midreset_id got %0d want %0d", active_id, DEF); end
        sel_strobe = 1'b0;
        steps(2);
        wb_rst_n = 1'b1;
        steps(25);
        n_vec++; if (active_valid !== 1'b1 || dsg_rst_n !== 4'b0001) begin n_err++; $display("FAIL midreset_restart got valid=%b rst=%b want 1/0001", active_valid, dsg_rst_n); end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        debug = 4'hA; sel_id = 4'hF; sel_strobe = 1'b1;
        steps(28);
        n_vec++; if (io_out[31:16] !== 16'hAA5A || io_oeb[31:16] !== 16'h0000) begin
            n_err++; $display("FAIL pattern_bits got out=%h oeb=%h want AA5A/0000", io_out[31:16], io_oeb[31:16]); end
        n_vec++; if (io_oeb[15:0] !== 16'hFFFF || io_oeb[IO_W-1:32] !== '1 || dsg_rst_n !== 4'b0000 || active_valid !== 1'b1) begin
            n_err++; $display("FAIL pattern_rest got oeb=%h rst=%b valid=%b", io_oeb, dsg_rst_n, active_valid); end
        strobe_low();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                sel_strobe = ~sel_strobe;
                if (sel_strobe) sel_id = 4'($urandom_range(0, 15));
            end
            debug = 4'($urandom);
            step();
            n_vec++;
            if (dsg_rst_n !== exp_rst || io_out !== exp_out || io_oeb !== exp_oeb ||
                busy !== exp_busy || active_valid !== exp_valid || active_id !== m_target) begin
                n_err++;
                $display("FAIL random_cycle_%0d got rst=%b busy=%b valid=%b id=%0d out=%h oeb=%h want rst=%b busy=%b valid=%b id=%0d out=%h oeb=%h",
                         k, dsg_rst_n, busy, active_valid, active_id, io_out, io_oeb,
                         exp_rst, exp_busy, exp_valid, m_target, exp_out, exp_oeb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_switch();
        test_same_id();
        test_retarget();
        test_unroutable();
        test_reset_mid();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
